// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
package imem_pkg;
    typedef enum logic [1:0] {
        ERR_OK           = 2'd0,
        ERR_MISALIGNED   = 2'd1,
        ERR_OUT_OF_RANGE = 2'd2
    } rsp_err_e;

    typedef enum logic {LOAD, SERVE} state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        rsp_err_e    err;
    } imem_rsp_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is legal when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: boot-loaded instruction RAM answering in-order fetches with
// one-cycle latency and a credit-limited response buffer.
module imem_responder import imem_pkg::*; #(
    parameter int DEPTH     = 256,
    parameter int RSP_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic [31:0]              rsp_pc,
    output logic [1:0]               rsp_err,
    input  logic                     ld_valid,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    input  logic                     ld_done,
    output logic                     loaded
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_DEPTH+1);

    state_e      state, state_next;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data, inflight_pc;
    rsp_err_e    inflight_err, req_err;
    logic        inflight, accept, push, pop, fifo_full, fifo_empty;
    logic [CW-1:0] count;
    imem_rsp_t   push_rsp, head;

    always_comb begin
        state_next = (state == LOAD && ld_done) ? SERVE : state;
        req_err    = req_addr[1:0] != 2'b00 ? ERR_MISALIGNED :
                     req_addr[31:2] >= 30'(DEPTH) ? ERR_OUT_OF_RANGE : ERR_OK;
    end

    assign loaded    = state == SERVE;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    // outstanding = buffered + in flight; a departing head frees one slot this cycle
    assign req_ready = loaded && ((32'(count) + 32'(inflight) < RSP_DEPTH) || pop);
    assign accept    = req_valid && req_ready;
    assign push      = inflight && (!fifo_full || pop);
    assign push_rsp  = '{instr: inflight_err == ERR_OK ? rd_data : NOP_INSTR,
                         pc: inflight_pc, err: inflight_err};
    assign rsp_instr = head.instr;
    assign rsp_pc    = head.pc;
    assign rsp_err   = head.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && ld_valid) mem[ld_addr] <= ld_data;
        if (accept) begin
            rd_data      <= mem[req_addr[AW+1:2]];
            inflight_pc  <= req_addr;
            inflight_err <= req_err;
        end
    end

    sync_fifo #(.WIDTH($bits(imem_rsp_t)), .DEPTH(RSP_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_rsp),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: random and directed fetch traffic checked against a
// queue-based model of outstanding responses.
module tb_imem_responder;
    localparam int DEPTH     = 256;
    localparam int RSP_DEPTH = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, rsp_ready = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
    logic [31:0] req_addr = '0, ld_data = '0;
    logic [7:0]  ld_addr = '0;
    logic        req_ready, rsp_valid, loaded;
    logic [31:0] rsp_instr, rsp_pc;
    logic [1:0]  rsp_err;

    imem_responder #(.DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .loaded(loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  err;
        int          stamp;
    } ent_t;

    logic [31:0] mmem [DEPTH];
    ent_t        q[$], got[$];
    bit          serve = 0, go = 0;
    int          ec = 0, acc = 0, checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_valid();
        return q.size() > 0 && q[0].stamp < ec;
    endfunction

    function automatic bit exp_ready();
        return serve && (q.size() < RSP_DEPTH || (exp_valid() && rsp_ready));
    endfunction

    function automatic ent_t model(input logic [31:0] a, input int stamp);
        ent_t e;
        e.pc = a;
        e.stamp = stamp;
        if (a % 4 != 0) begin e.err = 2'd1; e.instr = 32'h13; end
        else if (a >= 4 * DEPTH) begin e.err = 2'd2; e.instr = 32'h13; end
        else begin e.err = 2'd0; e.instr = mmem[a / 4]; end
        return e;
    endfunction

    always @(posedge clk) begin
        bit v, r;
        if (rst) begin
            q.delete();
            serve = 0;
        end else begin
            v = exp_valid();
            r = exp_ready();
            if (v && rsp_ready) begin
                got.push_back('{rsp_instr, rsp_pc, rsp_err, 0});
                void'(q.pop_front());
            end
            if (r && req_valid) begin
                q.push_back(model(req_addr, ec + 1));
                acc++;
            end
            if (!serve) begin
                if (ld_valid) mmem[ld_addr] = ld_data;
                if (ld_done) serve = 1;
            end
        end
        ec++;
    end

    always @(negedge clk) begin
        if (go) begin
            chk("loaded", {31'd0, loaded}, {31'd0, serve});
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready()});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid()});
            if (exp_valid()) begin
                chk("rsp_instr", rsp_instr, q[0].instr);
                chk("rsp_pc", rsp_pc, q[0].pc);
                chk("rsp_err", {30'd0, rsp_err}, {30'd0, q[0].err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a);
        bit ok = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready;
            tick();
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) tick();
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        int base;
        repeat (2) tick();
        go = 1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_pc", rsp_pc, 32'd0);
        chk("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
        chk("rst_loaded", {31'd0, loaded}, 32'd0);
        tick();
        rst = 1'b0;
        req_valid = 1'b1;
        repeat (4) tick();
        req_valid = 1'b0;
        chk("no_accept_in_load", acc, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5) continue;
            ld_valid = 1'b1;
            ld_addr  = 8'(i);
            ld_data  = i < 4 ? 32'((i + 1) * 'h11) : $urandom;
            tick();
        end
        ld_addr = 8'd5;
        ld_data = 32'hABCD;
        ld_done = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_done  = 1'b0;

        rsp_ready = 1'b1;
        base = got.size();
        for (int i = 0; i < 4; i++) send(32'(4 * i));
        drain();
        for (int i = 0; i < 4; i++) begin
            chk("seq_instr", got[base+i].instr, 32'((i + 1) * 'h11));
            chk("seq_pc", got[base+i].pc, 32'(4 * i));
            chk("seq_err", {30'd0, got[base+i].err}, 32'd0);
        end

        base = acc;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        repeat (6) tick();
        chk("bp_accepts", acc - base, 32'd2);
        base = got.size();
        drain();
        chk("bp_delivered", got.size() - base, 32'd2);

        base = got.size();
        send(32'h6);
        send(32'h8);
        send(32'h400);
        drain();
        chk("mis_err", {30'd0, got[base].err}, 32'd1);
        chk("mis_instr", got[base].instr, 32'h13);
        chk("ok_mid_instr", got[base+1].instr, 32'h33);
        chk("oor_err", {30'd0, got[base+2].err}, 32'd2);
        chk("oor_instr", got[base+2].instr, 32'h13);

        ld_valid = 1'b1;
        ld_addr  = 8'd0;
        ld_data  = 32'hDEAD;
        tick();
        ld_valid = 1'b0;
        send(32'h0);
        drain();
        chk("ro_in_serve", got[got.size()-1].instr, 32'h11);
        send(32'h14);
        drain();
        chk("ld_with_done", got[got.size()-1].instr, 32'hABCD);

        for (int n = 0; n < 3000; n++) begin
            req_valid = $urandom_range(0, 3) != 0;
            rsp_ready = $urandom_range(0, 3) != 0;
            ld_valid  = $urandom_range(0, 15) == 0;
            ld_done   = $urandom_range(0, 15) == 0;
            ld_addr   = 8'($urandom);
            ld_data   = $urandom;
            case ($urandom_range(0, 9))
                7:       req_addr = $urandom | 32'h1;
                8:       req_addr = ($urandom & ~32'h3) | 32'h400;
                9:       req_addr = $urandom;
                default: req_addr = {22'd0, 8'($urandom), 2'b00};
            endcase
            tick();
        end
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        drain();

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        repeat (4) tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_loaded", {31'd0, loaded}, 32'd0);
        tick();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        send(32'h4);
        drain();
        chk("retained", got[got.size()-1].instr, 32'h22);

        go = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
